// File: rtl/mode_ctrl_pkg.sv
// Shared definitions for the mode sequencer: state encodings,
// mode width and the modulo-4 advance helper.
package mode_ctrl_pkg;

    localparam int MODE_W    = 2;
    localparam int NUM_MODES = 4;

    localparam logic [MODE_W-1:0] MODE_ONE = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_BAD    = 2'b11
    } state_e;

    // Modulo-NUM_MODES step; natural 2-bit wrap does the work.
    function automatic logic [MODE_W-1:0] next_mode(
        input logic [MODE_W-1:0] m,
        input logic              up
    );
        return up ? m + MODE_ONE : m - MODE_ONE;
    endfunction

    // True when this advance crosses the 3<->0 boundary.
    function automatic logic is_wrap(
        input logic [MODE_W-1:0] m,
        input logic              up
    );
        return up ? (m == MODE_MAX) : (m == '0);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell down-counter: clear > reload > decrement; holds when not told.
// Ports: clk, rst (async active-low), clear, reload, dec, reload_val, count, expired.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               reload,
    input  logic               dec,
    input  logic [DWELL_W-1:0] reload_val,
    output logic [DWELL_W-1:0] count,
    output logic               expired
);

    logic [DWELL_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (reload) begin
            cnt_q <= reload_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DWELL_W'(1);
        end
    end

    assign count   = cnt_q;
    assign expired = (cnt_q == '0);

endmodule

// File: rtl/mode_sequencer_ctrl.sv
// Mode sequencer: FSM, mode counter, step handshake and pulse outputs.
// Ports: clk, rst (async active-low), start, stop, pause, dir, dwell,
//   load, load_val, step_req -> step_ack, mode, mode_oh, mode_chg, wrap, busy.
module mode_sequencer_ctrl
    import mode_ctrl_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               load,
    input  logic [1:0]         load_val,
    input  logic               step_req,
    output logic               step_ack,
    output logic [1:0]         mode,
    output logic [3:0]         mode_oh,
    output logic               mode_chg,
    output logic               wrap,
    output logic               busy
);

    state_e            state_q, state_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              ack_q, ack_d;
    logic              chg_q, chg_d;
    logic              wrap_q, wrap_d;

    logic               t_clear, t_reload, t_dec;
    logic               t_exp;
    logic [DWELL_W-1:0] t_count;
    logic               step_acc;
    logic               adv;

    dwell_timer #(
        .DWELL_W(DWELL_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (t_clear),
        .reload    (t_reload),
        .dec       (t_dec),
        .reload_val(dwell),
        .count     (t_count),
        .expired   (t_exp)
    );

    // A new request is only taken while the previous ack has dropped.
    assign step_acc = step_req & ~ack_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            ack_q   <= 1'b0;
            chg_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ack_q   <= ack_d;
            chg_q   <= chg_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        chg_d    = 1'b0;
        wrap_d   = 1'b0;
        t_clear  = 1'b0;
        t_reload = 1'b0;
        t_dec    = 1'b0;
        adv      = 1'b0;
        // Ack holds while req is high, drops the cycle after req falls.
        ack_d    = step_req & ack_q;

        if (stop) begin
            state_d = ST_IDLE;
            t_clear = 1'b1;
        end else if (load) begin
            mode_d   = load_val;
            t_reload = 1'b1;
            chg_d    = 1'b1;
        end else if (step_acc) begin
            adv   = 1'b1;
            ack_d = 1'b1;
        end else if ((state_q == ST_RUN) && t_exp) begin
            adv = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d  = ST_RUN;
                        t_reload = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        t_dec = 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (adv) begin
            mode_d   = next_mode(mode_q, dir);
            wrap_d   = is_wrap(mode_q, dir);
            chg_d    = 1'b1;
            t_reload = 1'b1;
        end

        // The unused encoding always recovers to IDLE.
        if (state_q == ST_BAD) begin
            state_d = ST_IDLE;
        end
    end

    assign step_ack = ack_q;
    assign mode     = mode_q;
    assign mode_oh  = NUM_MODES'(1) << mode_q;
    assign mode_chg = chg_q;
    assign wrap     = wrap_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
